// File: rtl/seg7_scan_driver.sv
// Time-multiplexed N-digit 7-segment driver with anode dead-time, blanking, DP and leading-zero suppression.
// Outputs registered one cycle after (cnt, idx); segment data is latched per slot so a load never tears a digit.
module seg7_scan_driver #(
   parameter int NUM_DIGITS     = 4,
   parameter int SCAN_DIV       = 50000,
   parameter int DEAD_CYCLES    = 2,
   parameter bit SEG_ACTIVE_LOW = 1'b1,
   parameter bit AN_ACTIVE_LOW  = 1'b1
) (
   input  logic                    clk,
   input  logic                    rst_n,
   input  logic                    enable,
   input  logic                    load,
   input  logic [4*NUM_DIGITS-1:0] iDIGITS,
   input  logic [NUM_DIGITS-1:0]   iDP,
   input  logic [NUM_DIGITS-1:0]   iBLANK,
   input  logic                    lz_en,
   input  logic                    hex_mode,
   output logic [6:0]              oSEG,
   output logic                    oDP,
   output logic [NUM_DIGITS-1:0]   oAN
);

   localparam int CNT_W = (SCAN_DIV > 1) ? $clog2(SCAN_DIV) : 1;
   localparam int IDX_W = (NUM_DIGITS > 1) ? $clog2(NUM_DIGITS) : 1;
   localparam logic [CNT_W-1:0]      CNT_LAST = CNT_W'(SCAN_DIV - 1);
   localparam logic [IDX_W-1:0]      IDX_LAST = IDX_W'(NUM_DIGITS - 1);
   localparam logic [6:0]            SEG_OFF  = {7{SEG_ACTIVE_LOW}};
   localparam logic                  DP_OFF   = SEG_ACTIVE_LOW;
   localparam logic [NUM_DIGITS-1:0] AN_OFF   = {NUM_DIGITS{AN_ACTIVE_LOW}};

   logic [4*NUM_DIGITS-1:0] r_digits;
   logic [NUM_DIGITS-1:0]   r_dp_snap;
   logic [NUM_DIGITS-1:0]   r_blank_snap;
   logic [CNT_W-1:0]        r_cnt;
   logic [IDX_W-1:0]        r_idx;
   logic [6:0]              r_seg;
   logic                    r_dp;
   logic [NUM_DIGITS-1:0]   r_an;

   logic [NUM_DIGITS-1:0]   w_zero_above;
   logic [3:0]              w_nib;
   logic                    w_dp_req;
   logic                    w_blank;
   logic                    w_zero_sel;
   logic [NUM_DIGITS-1:0]   w_an_onehot;
   logic                    w_suppress;
   logic [6:0]              w_seg_lit;
   logic [6:0]              w_seg_next;
   logic                    w_dp_next;
   logic [NUM_DIGITS-1:0]   w_an_next;
   logic                    w_dead;
   logic                    w_slot_start;
   logic                    w_slot_end;

   function automatic logic [6:0] f_glyph(input logic [3:0] nib, input logic hex);
      logic [6:0] g;
      case (nib)
         4'h0:    g = 7'h3F;
         4'h1:    g = 7'h06;
         4'h2:    g = 7'h5B;
         4'h3:    g = 7'h4F;
         4'h4:    g = 7'h66;
         4'h5:    g = 7'h6D;
         4'h6:    g = 7'h7D;
         4'h7:    g = 7'h07;
         4'h8:    g = 7'h7F;
         4'h9:    g = 7'h6F;
         4'hA:    g = 7'h77;
         4'hB:    g = 7'h7C;
         4'hC:    g = 7'h39;
         4'hD:    g = 7'h5E;
         4'hE:    g = 7'h79;
         default: g = 7'h71;
      endcase
      if (!hex && nib > 4'd9) g = 7'h40;
      return g;
   endfunction

   // Snapshot is captured regardless of enable so a disabled display can be preloaded.
   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         r_digits     <= '0;
         r_dp_snap    <= '0;
         r_blank_snap <= '0;
      end else if (load) begin
         r_digits     <= iDIGITS;
         r_dp_snap    <= iDP;
         r_blank_snap <= iBLANK;
      end
   end

   // Digit g is a suppression candidate when it and every more-significant nibble are zero.
   for (genvar g = 0; g < NUM_DIGITS; g++) begin : g_lz
      assign w_zero_above[g] = ~|r_digits[4*NUM_DIGITS-1:4*g];
   end

   always_comb begin
      w_nib       = '0;
      w_dp_req    = 1'b0;
      w_blank     = 1'b0;
      w_zero_sel  = 1'b0;
      w_an_onehot = '0;
      for (int i = 0; i < NUM_DIGITS; i++) begin
         if (r_idx == IDX_W'(i)) begin
            w_nib          = r_digits[4*i +: 4];
            w_dp_req       = r_dp_snap[i];
            w_blank        = r_blank_snap[i];
            w_zero_sel     = w_zero_above[i];
            w_an_onehot[i] = 1'b1;
         end
      end
   end

   assign w_suppress   = lz_en && (r_idx != '0) && w_zero_sel;
   assign w_seg_lit    = (w_blank || w_suppress) ? 7'h00 : f_glyph(w_nib, hex_mode);
   assign w_seg_next   = w_seg_lit ^ SEG_OFF;
   assign w_dp_next    = (w_dp_req && !w_blank) ^ DP_OFF;
   assign w_an_next    = w_an_onehot ^ AN_OFF;
   assign w_dead       = int'(r_cnt) < DEAD_CYCLES;
   assign w_slot_start = (r_cnt == '0);
   assign w_slot_end   = (r_cnt == CNT_LAST);

   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         r_cnt <= '0;
         r_idx <= '0;
      end else if (!enable) begin
         r_cnt <= '0;
         r_idx <= '0;
      end else if (w_slot_end) begin
         r_cnt <= '0;
         r_idx <= (r_idx == IDX_LAST) ? '0 : r_idx + IDX_W'(1);
      end else begin
         r_cnt <= r_cnt + CNT_W'(1);
      end
   end

   // Segment data only loads at slot start; the anode follows cnt every cycle for the dead-time.
   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         r_seg <= SEG_OFF;
         r_dp  <= DP_OFF;
         r_an  <= AN_OFF;
      end else if (!enable) begin
         r_seg <= SEG_OFF;
         r_dp  <= DP_OFF;
         r_an  <= AN_OFF;
      end else begin
         r_an <= w_dead ? AN_OFF : w_an_next;
         if (w_slot_start) begin
            r_seg <= w_seg_next;
            r_dp  <= w_dp_next;
         end
      end
   end

   assign oSEG = r_seg;
   assign oDP  = r_dp;
   assign oAN  = r_an;

endmodule

// File: tb/tb_seg7_scan_driver.sv
// Directed bench for seg7_scan_driver: 4 digits, 8-cycle slots, 2 dead cycles, active-low outputs.
module tb_seg7_scan_driver;

   logic        clk = 1'b0;
   logic        rst_n;
   logic        enable;
   logic        load;
   logic [15:0] iDIGITS;
   logic [3:0]  iDP;
   logic [3:0]  iBLANK;
   logic        lz_en;
   logic        hex_mode;
   logic [6:0]  oSEG;
   logic        oDP;
   logic [3:0]  oAN;

   int checks = 0;
   int errors = 0;

   logic [6:0] glyph [16] = '{7'h3F, 7'h06, 7'h5B, 7'h4F, 7'h66, 7'h6D, 7'h7D, 7'h07,
                              7'h7F, 7'h6F, 7'h77, 7'h7C, 7'h39, 7'h5E, 7'h79, 7'h71};
   logic [6:0] exp_seg;

   always #5 clk = ~clk;

   seg7_scan_driver #(
      .NUM_DIGITS(4), .SCAN_DIV(8), .DEAD_CYCLES(2),
      .SEG_ACTIVE_LOW(1'b1), .AN_ACTIVE_LOW(1'b1)
   ) dut (
      .clk(clk), .rst_n(rst_n), .enable(enable), .load(load),
      .iDIGITS(iDIGITS), .iDP(iDP), .iBLANK(iBLANK),
      .lz_en(lz_en), .hex_mode(hex_mode),
      .oSEG(oSEG), .oDP(oDP), .oAN(oAN)
   );

   task automatic tick();
      @(posedge clk);
      #1;
   endtask

   task automatic chk(input string tag, input logic [7:0] obs, input logic [7:0] exp);
      checks++;
      assert (obs === exp)
      else begin
         errors++;
         $error("FAIL %s observed %h expected %h", tag, obs, exp);
      end
   endtask

   task automatic load_word(input logic [15:0] d, input logic [3:0] dp, input logic [3:0] bl);
      iDIGITS = d;
      iDP     = dp;
      iBLANK  = bl;
      load    = 1'b1;
      tick();
      load    = 1'b0;
   endtask

   // Waits for the given anode to come on, bounded.
   task automatic wait_an(input logic [3:0] an, input string tag);
      int n = 0;
      while (oAN !== an && n < 200) begin
         tick();
         n++;
      end
      chk(tag, {4'h0, oAN}, {4'h0, an});
   endtask

   // Waits for a slot of the given anode that started after the current moment.
   task automatic wait_fresh(input logic [3:0] an, input string tag);
      int n = 0;
      while (oAN === 4'hF && n < 200) begin
         tick();
         n++;
      end
      while (oAN !== 4'hF && n < 200) begin
         tick();
         n++;
      end
      while (oAN !== an && n < 200) begin
         tick();
         n++;
      end
      chk(tag, {4'h0, oAN}, {4'h0, an});
   endtask

   initial begin
      #1000000;
      $display("FAIL watchdog expired observed running expected finished");
      $fatal(1, "watchdog");
   end

   initial begin
      rst_n    = 1'b1;
      enable   = 1'b0;
      load     = 1'b0;
      iDIGITS  = 16'h0000;
      iDP      = 4'h0;
      iBLANK   = 4'h0;
      lz_en    = 1'b0;
      hex_mode = 1'b1;
      #2 rst_n = 1'b0;
      #1;
      chk("rst_an",  {4'h0, oAN}, 8'h0F);
      chk("rst_seg", {1'b0, oSEG}, 8'h7F);
      chk("rst_dp",  {7'h0, oDP}, 8'h01);

      // Release with enable high; slot timing is checked cycle by cycle.
      enable  = 1'b1;
      iDIGITS = 16'h1234;
      load    = 1'b1;
      @(negedge clk);
      rst_n = 1'b1;
      tick();
      load = 1'b0;
      chk("dead0", {4'h0, oAN}, 8'h0F);
      tick();
      chk("dead1", {4'h0, oAN}, 8'h0F);
      tick();
      chk("slot0", {4'h0, oAN}, 8'h0E);
      repeat (5) tick();
      chk("slot0_end", {4'h0, oAN}, 8'h0E);
      tick();
      chk("gap0", {4'h0, oAN}, 8'h0F);
      tick();
      chk("gap1", {4'h0, oAN}, 8'h0F);
      tick();
      chk("slot1", {4'h0, oAN}, 8'h0D);
      chk("slot1_seg", {1'b0, oSEG}, 8'h30);
      repeat (8) tick();
      chk("slot2", {4'h0, oAN}, 8'h0B);
      repeat (8) tick();
      chk("slot3", {4'h0, oAN}, 8'h07);
      repeat (8) tick();
      chk("slot_wrap", {4'h0, oAN}, 8'h0E);

      // Asynchronous reset mid-scan.
      tick();
      tick();
      rst_n = 1'b0;
      #1;
      chk("midrst_an",  {4'h0, oAN}, 8'h0F);
      chk("midrst_seg", {1'b0, oSEG}, 8'h7F);
      chk("midrst_dp",  {7'h0, oDP}, 8'h01);
      @(negedge clk);
      rst_n = 1'b1;
      wait_fresh(4'h7, "snap_clr_an");
      chk("snap_clr_seg", {1'b0, oSEG}, 8'h40);

      // Decode of a multi-digit word.
      load_word(16'h1234, 4'h0, 4'h0);
      wait_fresh(4'hE, "dec_d0_an");
      chk("dec_d0", {1'b0, oSEG}, 8'h19);
      wait_fresh(4'h7, "dec_d3_an");
      chk("dec_d3", {1'b0, oSEG}, 8'h79);

      // Full glyph sweep through digit 0.
      for (int v = 0; v < 16; v++) begin
         load_word(16'(v), 4'h0, 4'h0);
         wait_fresh(4'hE, "sweep_an");
         exp_seg = ~glyph[v];
         chk($sformatf("sweep_%0h", v), {1'b0, oSEG}, {1'b0, exp_seg});
      end

      // Leading-zero suppression.
      lz_en = 1'b1;
      load_word(16'h0070, 4'h4, 4'h0);
      wait_fresh(4'h7, "lz_d3_an");
      chk("lz_d3_seg", {1'b0, oSEG}, 8'h7F);
      chk("lz_d3_dp",  {7'h0, oDP}, 8'h01);
      wait_fresh(4'hB, "lz_d2_an");
      chk("lz_d2_seg", {1'b0, oSEG}, 8'h7F);
      chk("lz_d2_dp",  {7'h0, oDP}, 8'h00);
      wait_fresh(4'hD, "lz_d1_an");
      chk("lz_d1_seg", {1'b0, oSEG}, 8'h78);
      wait_fresh(4'hE, "lz_d0_an");
      chk("lz_d0_seg", {1'b0, oSEG}, 8'h40);
      lz_en = 1'b0;
      wait_fresh(4'h7, "nolz_d3_an");
      chk("nolz_d3_seg", {1'b0, oSEG}, 8'h40);
      lz_en = 1'b1;
      load_word(16'h0000, 4'h0, 4'h0);
      wait_fresh(4'hD, "lz0_d1_an");
      chk("lz0_d1_seg", {1'b0, oSEG}, 8'h7F);
      wait_fresh(4'hE, "lz0_d0_an");
      chk("lz0_d0_seg", {1'b0, oSEG}, 8'h40);

      // BCD dash and blanking.
      lz_en    = 1'b0;
      hex_mode = 1'b0;
      load_word(16'h00A0, 4'h0, 4'h0);
      wait_fresh(4'hD, "bcd_d1_an");
      chk("bcd_d1_seg", {1'b0, oSEG}, 8'h3F);
      load_word(16'h00A0, 4'h1, 4'h1);
      wait_fresh(4'hE, "blank_d0_an");
      chk("blank_d0_seg", {1'b0, oSEG}, 8'h7F);
      chk("blank_d0_dp",  {7'h0, oDP}, 8'h01);

      // Load mid-slot must not tear the digit being shown.
      hex_mode = 1'b1;
      load_word(16'h1234, 4'h0, 4'h0);
      wait_fresh(4'hD, "tear_an");
      chk("tear_old", {1'b0, oSEG}, 8'h30);
      tick();
      load_word(16'h5555, 4'h0, 4'h0);
      repeat (3) tick();
      chk("tear_hold_an",  {4'h0, oAN}, 8'h0D);
      chk("tear_hold_seg", {1'b0, oSEG}, 8'h30);
      tick();
      chk("tear_gap", {4'h0, oAN}, 8'h0F);
      wait_an(4'hB, "tear_d2_an");
      chk("tear_d2_seg", {1'b0, oSEG}, 8'h12);

      // Enable drop, preload while disabled, restart at digit 0.
      wait_fresh(4'hE, "en_an");
      enable = 1'b0;
      tick();
      chk("dis_an",  {4'h0, oAN}, 8'h0F);
      chk("dis_seg", {1'b0, oSEG}, 8'h7F);
      chk("dis_dp",  {7'h0, oDP}, 8'h01);
      load_word(16'h0089, 4'h0, 4'h0);
      repeat (3) tick();
      chk("dis_hold_an", {4'h0, oAN}, 8'h0F);
      enable = 1'b1;
      tick();
      chk("reen_dead0", {4'h0, oAN}, 8'h0F);
      tick();
      chk("reen_dead1", {4'h0, oAN}, 8'h0F);
      tick();
      chk("reen_d0_an",  {4'h0, oAN}, 8'h0E);
      chk("reen_d0_seg", {1'b0, oSEG}, 8'h10);

      $display("CHECKS %0d ERRORS %0d", checks, errors);
      $finish;
   end

endmodule
